// File: rtl/instr_fetch_if.sv
// Instruction-memory fetch bus between instr_fetch_unit and instruction memory.
//   imem_req   : fetch request, held until imem_ack
//   imem_addr  : byte address of the fetch, stable while imem_req=1
//   imem_ack   : memory returns the word this cycle
//   imem_rdata : instruction word, valid with imem_ack
// master = fetch unit side, slave = memory side.
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches 32-bit words over a req/ack
// bus, holds each instruction for the datapath until exec_done, then picks
// the next PC from jr / J / taken branch / sequential. A watchdog stops
// fetching with a sticky fetch_err when memory never answers, and the HALT
// opcode parks the unit until reset.
// Ports:
//   clk, rst (async active-low)
//   imem        : fetch bus (instr_fetch_if.master)
//   instr       : instruction register, opcode = instr[31:26]
//   instr_valid : instruction is live (executing)
//   exec_done, J, beq, bne, jr, zero, jr_target : next-PC controls
//   pc, pc_plus4: current PC and its link value
//   halted, fetch_err : terminal status
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111,
  parameter int unsigned MAX_WAIT    = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  instr_fetch_if.master        imem,
  output logic [31:0]          instr,
  output logic [5:0]           opcode,
  output logic                 instr_valid,
  input  logic                 exec_done,
  input  logic                 J,
  input  logic                 beq,
  input  logic                 bne,
  input  logic                 jr,
  input  logic                 zero,
  input  logic [31:0]          jr_target,
  output logic [31:0]          pc,
  output logic [31:0]          pc_plus4,
  output logic                 halted,
  output logic                 fetch_err
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_EXEC = 2'd2;
  localparam logic [1:0] ST_HALT = 2'd3;

  // Last counter value before the watchdog fires: the error is raised in the
  // MAX_WAIT-th consecutive REQ cycle without an ack.
  localparam logic [15:0] WAIT_LAST = 16'(MAX_WAIT - 1);

  logic [1:0]  state_r, state_nxt_s;
  logic [31:0] pc_r, pc_nxt_s;
  logic [31:0] instr_r, instr_nxt_s;
  logic [15:0] wait_cnt_r, wait_cnt_nxt_s;
  logic        fetch_err_r, fetch_err_nxt_s;
  logic        req_r, valid_r, halted_r;
  logic [31:0] pc_plus4_s, br_off_s, next_pc_s;
  logic        br_taken_s;

  // Next-PC selection: jr beats J beats a taken branch beats sequential.
  always_comb begin
    pc_plus4_s = pc_r + 32'd4;
    br_off_s   = {{14{instr_r[15]}}, instr_r[15:0], 2'b00};
    br_taken_s = (beq & zero) | (bne & ~zero);
    if (jr) begin
      next_pc_s = {jr_target[31:2], 2'b00};
    end else if (J) begin
      next_pc_s = {pc_plus4_s[31:28], instr_r[25:0], 2'b00};
    end else if (br_taken_s) begin
      next_pc_s = pc_plus4_s + br_off_s;
    end else begin
      next_pc_s = pc_plus4_s;
    end
  end

  // Fetch sequencing: request, capture/watchdog, execute hold, halt.
  always_comb begin
    state_nxt_s     = state_r;
    pc_nxt_s        = pc_r;
    instr_nxt_s     = instr_r;
    wait_cnt_nxt_s  = wait_cnt_r;
    fetch_err_nxt_s = fetch_err_r;
    case (state_r)
      ST_IDLE: begin
        state_nxt_s = ST_REQ;
      end
      ST_REQ: begin
        if (imem.imem_ack) begin
          // An ack always wins over a watchdog expiry in the same cycle.
          instr_nxt_s    = imem.imem_rdata;
          wait_cnt_nxt_s = 16'd0;
          if (imem.imem_rdata[31:26] == HALT_OPCODE) begin
            state_nxt_s = ST_HALT;
          end else begin
            state_nxt_s = ST_EXEC;
          end
        end else if (wait_cnt_r == WAIT_LAST) begin
          fetch_err_nxt_s = 1'b1;
          wait_cnt_nxt_s  = 16'd0;
          state_nxt_s     = ST_HALT;
        end else begin
          wait_cnt_nxt_s = wait_cnt_r + 16'd1;
        end
      end
      ST_EXEC: begin
        if (exec_done) begin
          pc_nxt_s    = next_pc_s;
          state_nxt_s = ST_REQ;
        end else begin
          state_nxt_s = ST_EXEC;
        end
      end
      ST_HALT: begin
        state_nxt_s = ST_HALT;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers; status flags are registered from the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= ST_IDLE;
      pc_r        <= RESET_PC;
      instr_r     <= 32'd0;
      wait_cnt_r  <= 16'd0;
      fetch_err_r <= 1'b0;
      req_r       <= 1'b0;
      valid_r     <= 1'b0;
      halted_r    <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      pc_r        <= pc_nxt_s;
      instr_r     <= instr_nxt_s;
      wait_cnt_r  <= wait_cnt_nxt_s;
      fetch_err_r <= fetch_err_nxt_s;
      req_r       <= (state_nxt_s == ST_REQ);
      valid_r     <= (state_nxt_s == ST_EXEC);
      halted_r    <= (state_nxt_s == ST_HALT);
    end
  end

  assign imem.imem_req  = req_r;
  assign imem.imem_addr = pc_r;
  assign instr          = instr_r;
  assign opcode         = instr_r[31:26];
  assign instr_valid    = valid_r;
  assign pc             = pc_r;
  assign pc_plus4       = pc_plus4_s;
  assign halted         = halted_r;
  assign fetch_err      = fetch_err_r;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed table of fetch/execute
// transactions, randomized transactions against a transaction-level next-PC
// model, and hand-written watchdog, halt and reset sequences.
module tb_instr_fetch_unit;

  typedef struct {
    logic [31:0] word;
    int          d;
    int          e;
    logic        j;
    logic        beq;
    logic        bne;
    logic        jr;
    logic        zero;
    logic [31:0] jr_target;
    logic [31:0] exp_next;
  } vec_t;

  logic        clk;
  logic        rst;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic        instr_valid;
  logic        exec_done;
  logic        j_in;
  logic        beq;
  logic        bne;
  logic        jr;
  logic        zero;
  logic [31:0] jr_target;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        halted;
  logic        fetch_err;

  int vectors     = 0;
  int miscompares = 0;

  instr_fetch_if bus ();

  instr_fetch_unit #(
    .RESET_PC    (32'h0000_0000),
    .HALT_OPCODE (6'b111111),
    .MAX_WAIT    (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem        (bus),
    .instr       (instr),
    .opcode      (opcode),
    .instr_valid (instr_valid),
    .exec_done   (exec_done),
    .J           (j_in),
    .beq         (beq),
    .bne         (bne),
    .jr          (jr),
    .zero        (zero),
    .jr_target   (jr_target),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .halted      (halted),
    .fetch_err   (fetch_err)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard time limit so the run can never hang
  initial begin
    #200000;
    $display("FAIL global_timeout: got no end of test, expected finish");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic clear_ctrl;
    exec_done = 1'b0;
    j_in      = 1'b0;
    beq       = 1'b0;
    bne       = 1'b0;
    jr        = 1'b0;
    zero      = 1'b0;
    jr_target = 32'd0;
  endtask

  // Next-PC reference from the architectural rules, in plain arithmetic.
  function automatic logic [31:0] model_next(input logic [31:0] cur, input vec_t v);
    logic [31:0] seq;
    int          off;
    seq = cur + 32'd4;
    off = $signed(v.word[15:0]) * 4;
    if (v.jr) return v.jr_target & 32'hFFFF_FFFC;
    if (v.j) return (seq & 32'hF000_0000) + ({6'd0, v.word[25:0]} * 32'd4);
    if ((v.beq && v.zero) || (v.bne && !v.zero)) return seq + 32'(off);
    return seq;
  endfunction

  // Assert reset, check the immediate reset state, release, see the first request.
  task automatic do_reset;
    rst = 1'b0;
    #1;
    chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
    chk("rst_addr", bus.imem_addr, 32'h0000_0000);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_err", {31'd0, fetch_err}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_pc", pc, 32'h0000_0000);
    tick;
    tick;
    rst = 1'b1;
    chk("release_req_low", {31'd0, bus.imem_req}, 32'd0);
    tick;
    chk("first_req", {31'd0, bus.imem_req}, 32'd1);
    chk("first_addr", bus.imem_addr, 32'h0000_0000);
  endtask

  // One fetch/execute transaction starting in the request phase at exp_addr.
  task automatic run_vec(input vec_t v, input logic [31:0] exp_addr);
    for (int k = 0; k < 8 && !bus.imem_req; k++) tick;
    chk("req_high", {31'd0, bus.imem_req}, 32'd1);
    chk("fetch_addr", bus.imem_addr, exp_addr);
    chk("pc", pc, exp_addr);
    for (int k = 0; k < v.d; k++) begin
      bus.imem_ack = 1'b0;
      tick;
      chk("req_hold", {31'd0, bus.imem_req}, 32'd1);
      chk("addr_hold", bus.imem_addr, exp_addr);
    end
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = v.word;
    tick;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = $urandom;
    chk("instr_valid", {31'd0, instr_valid}, 32'd1);
    chk("instr", instr, v.word);
    chk("opcode", {26'd0, opcode}, {26'd0, v.word[31:26]});
    chk("req_low_exec", {31'd0, bus.imem_req}, 32'd0);
    chk("pc_plus4", pc_plus4, exp_addr + 32'd4);
    for (int k = 0; k < v.e; k++) begin
      bus.imem_ack   = 1'($urandom);
      bus.imem_rdata = $urandom;
      j_in           = 1'($urandom);
      beq            = 1'($urandom);
      bne            = 1'($urandom);
      jr             = 1'($urandom);
      zero           = 1'($urandom);
      tick;
      chk("exec_hold_valid", {31'd0, instr_valid}, 32'd1);
      chk("exec_hold_instr", instr, v.word);
      chk("exec_hold_pc", pc, exp_addr);
    end
    bus.imem_ack = 1'b0;
    exec_done    = 1'b1;
    j_in         = v.j;
    beq          = v.beq;
    bne          = v.bne;
    jr           = v.jr;
    zero         = v.zero;
    jr_target    = v.jr_target;
    tick;
    clear_ctrl;
    chk("next_req", {31'd0, bus.imem_req}, 32'd1);
    chk("next_addr", bus.imem_addr, v.exp_next);
    chk("next_valid_low", {31'd0, instr_valid}, 32'd0);
  endtask

  vec_t        vecs[14];
  vec_t        v;
  logic [31:0] cur_pc;
  logic [31:0] hw;

  initial begin
    // word, ack delay, exec delay, J, beq, bne, jr, zero, jr_target, expected next fetch
    vecs[0]  = '{32'h0400_0005, 3, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0004};
    vecs[1]  = '{32'h2000_0000, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0013, 32'h0000_0010};
    vecs[2]  = '{32'h1000_FFFE, 1, 2, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0000_000C};
    vecs[3]  = '{32'h2000_0001, 2, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0010};
    vecs[4]  = '{32'h1000_FFFE, 0, 1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0014};
    vecs[5]  = '{32'h2000_0002, 1, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_0010, 32'h0000_0010};
    vecs[6]  = '{32'h1400_FFFE, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0000_000C};
    vecs[7]  = '{32'h2000_0003, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h4000_0020, 32'h4000_0020};
    vecs[8]  = '{32'h0800_0100, 2, 1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h4000_0400};
    vecs[9]  = '{32'h2000_0004, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h4000_0020, 32'h4000_0020};
    vecs[10] = '{32'h0800_0100, 1, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0000_1237, 32'h0000_1234};
    vecs[11] = '{32'h2000_0005, 0, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC};
    vecs[12] = '{32'h0000_0000, 3, 2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0000};
    vecs[13] = '{32'h1000_0004, 0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0, 32'h0000_0014};

    rst            = 1'b1;
    bus.imem_ack   = 1'b0;
    bus.imem_rdata = 32'd0;
    clear_ctrl;
    @(posedge clk);
    #1;
    do_reset;

    // Directed table
    cur_pc = 32'h0000_0000;
    for (int i = 0; i < 14; i++) begin
      run_vec(vecs[i], cur_pc);
      cur_pc = vecs[i].exp_next;
    end

    // Randomized transactions against the next-PC model
    for (int i = 0; i < 40; i++) begin
      hw = $urandom;
      if (hw[31:26] == 6'b111111) hw[31:26] = 6'b000000;
      v.word      = hw;
      v.d         = $urandom_range(0, 3);
      v.e         = $urandom_range(0, 4);
      v.jr        = ($urandom_range(0, 7) == 0);
      v.j         = ($urandom_range(0, 3) == 0);
      v.beq       = 1'($urandom);
      v.bne       = 1'($urandom);
      v.zero      = 1'($urandom);
      v.jr_target = $urandom;
      v.exp_next  = model_next(cur_pc, v);
      run_vec(v, cur_pc);
      cur_pc = v.exp_next;
    end

    // Watchdog: no ack for MAX_WAIT=4 request cycles
    bus.imem_ack = 1'b0;
    chk("wd_entry_req", {31'd0, bus.imem_req}, 32'd1);
    for (int k = 0; k < 3; k++) begin
      tick;
      chk("wd_wait_req", {31'd0, bus.imem_req}, 32'd1);
      chk("wd_wait_err", {31'd0, fetch_err}, 32'd0);
      chk("wd_wait_halted", {31'd0, halted}, 32'd0);
    end
    tick;
    chk("wd_err", {31'd0, fetch_err}, 32'd1);
    chk("wd_halted", {31'd0, halted}, 32'd1);
    chk("wd_req_drop", {31'd0, bus.imem_req}, 32'd0);
    tick;
    chk("wd_err_sticky", {31'd0, fetch_err}, 32'd1);
    chk("wd_req_stays_low", {31'd0, bus.imem_req}, 32'd0);
    do_reset;

    // Ack in the 4th request cycle wins over the watchdog
    v = '{32'h0400_0005, 3, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0000_0004};
    run_vec(v, 32'h0000_0000);
    chk("late_ack_no_err", {31'd0, fetch_err}, 32'd0);
    chk("late_ack_not_halted", {31'd0, halted}, 32'd0);

    // HALT opcode: stop fetching, ignore everything until reset
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'hFC00_1234;
    tick;
    bus.imem_ack = 1'b0;
    chk("halt_halted", {31'd0, halted}, 32'd1);
    chk("halt_instr", instr, 32'hFC00_1234);
    chk("halt_pc", pc, 32'h0000_0004);
    chk("halt_valid", {31'd0, instr_valid}, 32'd0);
    for (int k = 0; k < 20; k++) begin
      bus.imem_ack   = 1'($urandom);
      bus.imem_rdata = $urandom;
      exec_done      = 1'($urandom);
      jr             = 1'($urandom);
      jr_target      = $urandom;
      tick;
      chk("halt_no_req", {31'd0, bus.imem_req}, 32'd0);
      chk("halt_stays", {31'd0, halted}, 32'd1);
      chk("halt_pc_hold", pc, 32'h0000_0004);
    end
    bus.imem_ack = 1'b0;
    clear_ctrl;
    do_reset;

    // Reset during a request while the ack arrives: response not captured
    bus.imem_ack   = 1'b1;
    bus.imem_rdata = 32'h0400_0005;
    #2;
    rst = 1'b0;
    #1;
    chk("midreq_req", {31'd0, bus.imem_req}, 32'd0);
    chk("midreq_valid", {31'd0, instr_valid}, 32'd0);
    chk("midreq_instr", instr, 32'd0);
    @(posedge clk);
    #1;
    chk("midreq_instr_after_edge", instr, 32'd0);
    chk("midreq_valid_after_edge", {31'd0, instr_valid}, 32'd0);
    bus.imem_ack = 1'b0;
    rst = 1'b1;
    tick;
    chk("midreq_restart_req", {31'd0, bus.imem_req}, 32'd1);
    chk("midreq_restart_addr", bus.imem_addr, 32'h0000_0000);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
